// File: rtl/mem_sweep_ctrl_pkg.sv
// ============================================================================
// Module : mem_sweep_ctrl_pkg
// Brief  : Shared mode/state encodings and the fill/verify pattern function
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mem_sweep_ctrl_pkg;

  localparam int PAT_W = 64;

  typedef enum logic [1:0] {
    MODE_READ   = 2'd0,
    MODE_FILL   = 2'd1,
    MODE_VERIFY = 2'd2,
    MODE_LOOP   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Callers cast the result down to their data width.
  function automatic logic [PAT_W-1:0] pattern(input logic [PAT_W-1:0] addr,
                                               input logic [PAT_W-1:0] seed);
    return addr ^ seed;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_sweep_ctrl_prescaler.sv
// ============================================================================
// Module : sweep_prescaler
// Brief  : Enable-gated 0..DIV-1 counter producing a one-clock access tick
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sweep_prescaler #(
  parameter int DIV  = 50000000,
  parameter int DIVW = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  output logic o_tick
);

  localparam logic [DIVW-1:0] c_term_cnt = DIVW'(DIV - 1);

  logic [DIVW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == c_term_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!i_en || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_sweep_ctrl.sv
// ============================================================================
// Module : mem_sweep_ctrl
// Brief  : Prescaled single-port RAM sweep engine (read / fill / verify / loop)
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_sweep_ctrl
  import mem_sweep_ctrl_pkg::*;
#(
  parameter int            AW        = 16,
  parameter int            DW        = 16,
  parameter int            LAST_ADDR = 2**AW - 1,
  parameter int            DIV       = 50000000,
  parameter int            DIVW      = 26,
  parameter logic [DW-1:0] SEED      = DW'(16'hA5A5),
  localparam int           BSW       = (DW > 8) ? $clog2(DW / 8) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           stop,
  input  logic [1:0]     mode,
  input  logic [BSW-1:0] byte_sel,
  output logic [AW-1:0]  mem_addr,
  output logic           mem_we,
  output logic [DW-1:0]  mem_din,
  input  logic [DW-1:0]  mem_dout,
  output logic [7:0]     dataout,
  output logic           busy,
  output logic           done,
  output logic [AW:0]    err_cnt
);

  localparam logic [AW-1:0] c_last_addr = AW'(LAST_ADDR);
  localparam logic [AW:0]   c_err_max   = '1;

  state_e         r_state;
  state_e         w_next;
  mode_e          r_mode;
  logic [AW-1:0]  r_addr;
  logic           r_rd_valid;
  logic [DW-1:0]  r_exp;
  logic [7:0]     r_dataout;
  logic [AW:0]    r_err;

  logic           w_run;
  logic           w_tick;
  logic           w_access;
  logic           w_start_ok;
  logic           w_last;
  logic [DW-1:0]  w_pat;
  logic [7:0]     w_byte;

  assign w_run      = (r_state == ST_RUN);
  // A coincident stop suppresses the access of that tick.
  assign w_access   = w_run && w_tick && !stop;
  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last     = (r_addr == c_last_addr);
  assign w_pat      = DW'(pattern(PAT_W'(r_addr), PAT_W'(SEED)));

  sweep_prescaler #(
    .DIV  (DIV),
    .DIVW (DIVW)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .i_en   (w_run),
    .o_tick (w_tick)
  );

  always_comb begin
    w_byte = mem_dout[7:0];
    for (int i = 0; i < DW / 8; i++) begin
      if (byte_sel == BSW'(i)) begin
        w_byte = mem_dout[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) w_next = ST_RUN;
      end
      ST_RUN: begin
        if (stop || (w_access && w_last && (r_mode != MODE_LOOP))) begin
          w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: w_next = ST_DONE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode     <= MODE_READ;
      r_addr     <= '0;
      r_rd_valid <= 1'b0;
      r_exp      <= '0;
      r_dataout  <= '0;
      r_err      <= '0;
    end else begin
      if (w_start_ok) begin
        r_mode <= mode_e'(mode);
      end

      if (r_state == ST_DRAIN) begin
        r_addr <= '0;
      end else if (w_access) begin
        r_addr <= w_last ? '0 : r_addr + 1'b1;
      end

      r_rd_valid <= w_access && (r_mode != MODE_FILL);
      if (w_access) begin
        r_exp <= w_pat;
      end

      if (r_rd_valid) begin
        r_dataout <= w_byte;
      end

      // Start never coincides with read-back, so clear and count cannot collide.
      if (w_start_ok && (mode == MODE_VERIFY)) begin
        r_err <= '0;
      end else if (r_rd_valid && (r_mode == MODE_VERIFY) &&
                   (mem_dout != r_exp) && (r_err != c_err_max)) begin
        r_err <= r_err + 1'b1;
      end
    end
  end

  assign mem_addr = r_addr;
  assign mem_we   = w_access && (r_mode == MODE_FILL);
  assign mem_din  = mem_we ? w_pat : '0;
  assign dataout  = r_dataout;
  assign busy     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done     = (r_state == ST_DONE);
  assign err_cnt  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_sweep_ctrl.sv
// ============================================================================
// Module : tb_mem_sweep_ctrl
// Brief  : Scoreboard bench for mem_sweep_ctrl with a behavioural 1-cycle RAM
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_sweep_ctrl;
  import mem_sweep_ctrl_pkg::*;

  localparam logic [15:0] SEED = 16'hA5A5;

  logic        clk = 1'b0;
  logic        reset, start, stop;
  logic [1:0]  mode;
  logic [0:0]  byte_sel;
  logic [3:0]  mem_addr;
  logic        mem_we;
  logic [15:0] mem_din, mem_dout;
  logic [7:0]  dataout;
  logic        busy, done;
  logic [4:0]  err_cnt;

  logic        d4_start, d4_stop;
  logic [1:0]  d4_mode;
  logic [0:0]  d4_byte_sel;
  logic [3:0]  d4_addr;
  logic        d4_we;
  logic [15:0] d4_din, d4_dout;
  logic [7:0]  d4_dataout;
  logic        d4_busy, d4_done;
  logic [4:0]  d4_err;

  logic [15:0] ram [16];
  logic        bk_we;
  logic [3:0]  bk_addr;
  logic [15:0] bk_data;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { logic [3:0] addr; logic [15:0] data; } wr_t;
  typedef struct { int due; logic [7:0] val; } rd_t;
  wr_t        wq[$];
  rd_t        rq[$];
  logic [3:0] aq[$];

  always #5 clk = ~clk;

  mem_sweep_ctrl #(
    .AW(4), .DW(16), .LAST_ADDR(15), .DIV(1), .DIVW(2), .SEED(16'hA5A5)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .byte_sel(byte_sel), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_din(mem_din), .mem_dout(mem_dout), .dataout(dataout),
    .busy(busy), .done(done), .err_cnt(err_cnt)
  );

  mem_sweep_ctrl #(
    .AW(4), .DW(16), .LAST_ADDR(15), .DIV(4), .DIVW(2), .SEED(16'hA5A5)
  ) dut4 (
    .clk(clk), .reset(reset), .start(d4_start), .stop(d4_stop), .mode(d4_mode),
    .byte_sel(d4_byte_sel), .mem_addr(d4_addr), .mem_we(d4_we),
    .mem_din(d4_din), .mem_dout(d4_dout), .dataout(d4_dataout),
    .busy(d4_busy), .done(d4_done), .err_cnt(d4_err)
  );

  always @(posedge clk) begin
    if (bk_we) ram[bk_addr] <= bk_data;
    else if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  function automatic logic [15:0] exp_pat(input int a);
    return 16'(a) ^ SEED;
  endfunction

  task automatic pulse_start(input logic [1:0] m);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic bk_write(input logic [3:0] a, input logic [15:0] d);
    bk_addr = a;
    bk_data = d;
    bk_we   = 1'b1;
    @(negedge clk);
    bk_we   = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    for (int i = 0; i < budget && done !== 1'b1; i++) @(negedge clk);
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL %s_done: done=%b required 1 within %0d clk", tag, done, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0; byte_sel = 1'b0;
    d4_start = 1'b0; d4_stop = 1'b0; d4_mode = 2'd0; d4_byte_sel = 1'b0;
    d4_dout = 16'h0000; bk_we = 1'b0; bk_addr = 4'd0; bk_data = 16'h0000;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({mem_addr, mem_we, mem_din, dataout, busy, done, err_cnt} !== 39'd0) begin
      n_err++;
      $display("FAIL reset_outputs: addr=%h we=%b din=%h dout=%h busy=%b done=%b err=%h required all 0",
               mem_addr, mem_we, mem_din, dataout, busy, done, err_cnt);
    end
    n_cmp++;
    if ({d4_addr, d4_we, d4_din, d4_dataout, d4_busy, d4_done, d4_err} !== 39'd0) begin
      n_err++;
      $display("FAIL reset_outputs_div4: addr=%h we=%b busy=%b done=%b required all 0",
               d4_addr, d4_we, d4_busy, d4_done);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, mem_we} !== 3'b000) begin
      n_err++;
      $display("FAIL idle_after_reset: busy=%b done=%b we=%b required 0 0 0", busy, done, mem_we);
    end
  endtask

  task automatic test_fill();
    int  last   = -100;
    int  done_c = -1;
    wr_t e;
    wq.delete();
    for (int a = 0; a < 16; a++) wq.push_back('{4'(a), exp_pat(a)});
    pulse_start(MODE_FILL);
    for (int c = 0; c < 30; c++) begin
      if (mem_we === 1'b1) begin
        n_cmp++;
        if (wq.size() == 0) begin
          n_err++;
          $display("FAIL fill_extra_write: addr=%h data=%h required no write", mem_addr, mem_din);
        end else begin
          e = wq.pop_front();
          if ({mem_addr, mem_din} !== {e.addr, e.data}) begin
            n_err++;
            $display("FAIL fill_write: addr=%h data=%h required addr=%h data=%h",
                     mem_addr, mem_din, e.addr, e.data);
          end
        end
        last = c;
      end
      if (done === 1'b1 && done_c < 0) done_c = c;
      @(negedge clk);
    end
    n_cmp++;
    if (wq.size() != 0) begin
      n_err++;
      $display("FAIL fill_missing_writes: %0d left required 0", wq.size());
    end
    n_cmp++;
    if (done_c != last + 2) begin
      n_err++;
      $display("FAIL fill_done_timing: done at clk %0d required %0d", done_c, last + 2);
    end
    n_cmp++;
    if (ram[3] !== 16'hA5A6) begin
      n_err++;
      $display("FAIL fill_ram3: ram[3]=%h required a5a6", ram[3]);
    end
  endtask

  task automatic test_verify(input logic [4:0] exp_err, input string tag);
    pulse_start(MODE_VERIFY);
    n_cmp++;
    if (err_cnt !== 5'd0) begin
      n_err++;
      $display("FAIL %s_clear: err_cnt=%0d required 0 after start", tag, err_cnt);
    end
    wait_done(40, tag);
    n_cmp++;
    if (err_cnt !== exp_err) begin
      n_err++;
      $display("FAIL %s_errcnt: err_cnt=%0d required %0d", tag, err_cnt, exp_err);
    end
  endtask

  task automatic test_read(input logic [0:0] bsel);
    logic [3:0] prev;
    rd_t        e;
    logic [15:0] p;
    byte_sel = bsel;
    rq.delete();
    pulse_start(MODE_READ);
    prev = mem_addr;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      while (rq.size() > 0 && rq[0].due == c) begin
        e = rq.pop_front();
        n_cmp++;
        if (dataout !== e.val) begin
          n_err++;
          $display("FAIL read_b%0d_dataout: dataout=%h required %h", bsel, dataout, e.val);
        end
      end
      if (mem_addr !== prev) begin
        p = exp_pat(int'(prev));
        rq.push_back('{c + 1, bsel ? p[15:8] : p[7:0]});
      end
      prev = mem_addr;
    end
    n_cmp++;
    if (rq.size() != 0 || done !== 1'b1) begin
      n_err++;
      $display("FAIL read_b%0d_end: pending=%0d done=%b required 0 and 1", bsel, rq.size(), done);
    end
  endtask

  task automatic test_back_to_back();
    int         last = -1;
    int         nw   = 0;
    logic [3:0] ea;
    aq.delete();
    for (int a = 0; a < 16; a++) aq.push_back(4'(a));
    d4_mode  = MODE_FILL;
    d4_start = 1'b1;
    @(negedge clk);
    d4_start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (c == 20) begin
        d4_mode  = MODE_READ;
        d4_start = 1'b1;
      end else begin
        d4_start = 1'b0;
      end
      if (d4_we === 1'b1) begin
        ea = (aq.size() > 0) ? aq.pop_front() : 4'hX;
        n_cmp++;
        if (d4_addr !== ea) begin
          n_err++;
          $display("FAIL div4_addr: addr=%h required %h", d4_addr, ea);
        end
        if (last >= 0) begin
          n_cmp++;
          if (c - last != 4) begin
            n_err++;
            $display("FAIL div4_spacing: gap=%0d clk required 4", c - last);
          end
        end
        last = c;
        nw++;
      end
      if (d4_done === 1'b1) break;
      @(negedge clk);
    end
    d4_start = 1'b0;
    n_cmp++;
    if (nw != 16 || d4_done !== 1'b1) begin
      n_err++;
      $display("FAIL div4_count: writes=%0d done=%b required 16 and 1", nw, d4_done);
    end
  endtask

  task automatic test_loop_stop();
    logic [3:0] prev;
    logic [3:0] nxt;
    byte_sel = 1'b0;
    pulse_start(MODE_LOOP);
    prev = mem_addr;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      nxt = prev + 4'd1;
      n_cmp++;
      if ({busy, mem_addr} !== {1'b1, nxt}) begin
        n_err++;
        $display("FAIL loop_addr: busy=%b addr=%h required 1 %h", busy, mem_addr, nxt);
      end
      prev = mem_addr;
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_cmp++;
    if ({busy, done, mem_addr} !== {1'b1, 1'b0, 4'd4}) begin
      n_err++;
      $display("FAIL loop_stop_drain: busy=%b done=%b addr=%h required 1 0 4", busy, done, mem_addr);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, done, mem_addr, dataout} !== {1'b0, 1'b1, 4'd0, 8'hA6}) begin
      n_err++;
      $display("FAIL loop_stop_done: busy=%b done=%b addr=%h dout=%h required 0 1 0 a6",
               busy, done, mem_addr, dataout);
    end
  endtask

  task automatic test_reset_mid_fill();
    bk_write(4'd9, 16'h0000);
    pulse_start(MODE_FILL);
    for (int c = 0; c < 30 && !(mem_addr === 4'd9 && mem_we === 1'b1); c++) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if ({mem_addr, mem_we, mem_din, dataout, busy, done, err_cnt} !== 39'd0) begin
      n_err++;
      $display("FAIL midfill_reset: addr=%h we=%b din=%h dout=%h busy=%b done=%b err=%h required all 0",
               mem_addr, mem_we, mem_din, dataout, busy, done, err_cnt);
    end
    @(negedge clk);
    n_cmp++;
    if (ram[9] !== 16'h0000 || ram[8] !== exp_pat(8)) begin
      n_err++;
      $display("FAIL midfill_ram: ram[8]=%h ram[9]=%h required %h 0000", ram[8], ram[9], exp_pat(8));
    end
    reset = 1'b0;
    @(negedge clk);
    pulse_start(MODE_FILL);
    n_cmp++;
    if ({mem_we, mem_addr} !== {1'b1, 4'd0}) begin
      n_err++;
      $display("FAIL restart_addr: we=%b addr=%h required 1 0", mem_we, mem_addr);
    end
    wait_done(40, "restart");
    n_cmp++;
    if (ram[9] !== exp_pat(9)) begin
      n_err++;
      $display("FAIL restart_ram9: ram[9]=%h required %h", ram[9], exp_pat(9));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_verify(5'd0, "verify_clean");
    bk_write(4'd7, 16'h1234);
    test_verify(5'd1, "verify_corrupt");
    test_verify(5'd1, "verify_rerun");
    bk_write(4'd7, exp_pat(7));
    test_read(1'b1);
    test_read(1'b0);
    test_back_to_back();
    test_loop_stop();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
